// File: rtl/spi_sensor_poll_pkg.sv
// Shared types and SPI command bytes for the multi-sensor poller.
// Imported by spi_xfer_seq and spi_sensor_poll_multi.
package spi_sensor_poll_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PERIOD,
    ST_CFG_XFER,
    ST_CONV_WAIT,
    ST_READ_XFER,
    ST_COMPARE,
    ST_NEXT,
    ST_REPORT
  } poll_state_e;

  typedef enum logic [2:0] {
    XS_IDLE,
    XS_WRITE,
    XS_WAIT_TX,
    XS_WAIT_DONE,
    XS_POP
  } xfer_state_e;

  localparam logic [7:0] CMD_WR_CFG  = 8'h08;
  localparam logic [7:0] CFG_ONESHOT = 8'h20;
  localparam logic [7:0] CMD_RD_TEMP = 8'h50;
  localparam logic [7:0] DUMMY       = 8'hFF;

  function automatic logic [7:0] tx_byte(
    input logic       rd,
    input logic [2:0] idx
  );
    if (idx == 3'd0) return rd ? CMD_RD_TEMP : CMD_WR_CFG;
    return rd ? DUMMY : CFG_ONESHOT;
  endfunction

endpackage

// File: rtl/spi_xfer_seq.sv
// One chip-select framed SPI transaction: config write or
// temperature read with RX pop and MSB-first assembly.
module spi_xfer_seq
  import spi_sensor_poll_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_BYTES = 2,
  parameter int CH_W       = 1,
  localparam int VALUE_W   = 8 * DATA_BYTES
) (
  input  logic               Clk_i,
  input  logic               Reset_n_i,
  input  logic               Start_i,
  input  logic               Read_i,
  input  logic [CH_W-1:0]    Ch_i,
  output logic [NUM_CH-1:0]  CS_n_o,
  output logic [7:0]         Data_o,
  output logic               Write_o,
  output logic               ReadNext_o,
  input  logic [7:0]         RxData_i,
  input  logic               FIFOFull_i,
  input  logic               FIFOEmpty_i,
  input  logic               Transmission_i,
  output logic               Done_o,
  output logic [VALUE_W-1:0] Value_o
);

  localparam logic [2:0] RD_LAST = 3'(DATA_BYTES);

  xfer_state_e        st_q;
  logic               rd_q;
  logic [2:0]         idx_q;
  logic [NUM_CH-1:0]  cs_n_q;
  logic [7:0]         data_q;
  logic               wr_q;
  logic               rn_q;
  logic               done_q;
  logic [VALUE_W-1:0] val_q;
  logic [2:0]         last_d;

  assign last_d = rd_q ? RD_LAST : 3'd1;

  // A gap cycle after each write lets FIFOFull_i reflect that push
  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      st_q   <= XS_IDLE;
      rd_q   <= 1'b0;
      idx_q  <= '0;
      cs_n_q <= '1;
      data_q <= '0;
      wr_q   <= 1'b0;
      rn_q   <= 1'b0;
      done_q <= 1'b0;
      val_q  <= '0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (st_q)
        XS_IDLE: begin
          if (Start_i) begin
            rd_q   <= Read_i;
            idx_q  <= '0;
            cs_n_q <= ~(NUM_CH'(1) << Ch_i);
            st_q   <= XS_WRITE;
          end
        end
        XS_WRITE: begin
          if (!wr_q && !FIFOFull_i) begin
            wr_q   <= 1'b1;
            data_q <= tx_byte(rd_q, idx_q);
            idx_q  <= idx_q + 3'd1;
            if (idx_q == last_d) st_q <= XS_WAIT_TX;
          end
        end
        XS_WAIT_TX: begin
          if (Transmission_i) st_q <= XS_WAIT_DONE;
        end
        XS_WAIT_DONE: begin
          if (!Transmission_i && FIFOEmpty_i) begin
            cs_n_q <= '1;
            if (rd_q) begin
              rn_q  <= 1'b1;
              idx_q <= '0;
              val_q <= '0;
              st_q  <= XS_POP;
            end else begin
              done_q <= 1'b1;
              st_q   <= XS_IDLE;
            end
          end
        end
        XS_POP: begin
          if (idx_q != 3'd0)
            val_q <= (val_q << 8) | VALUE_W'(RxData_i);
          idx_q <= idx_q + 3'd1;
          if (idx_q == RD_LAST) begin
            rn_q   <= 1'b0;
            done_q <= 1'b1;
            st_q   <= XS_IDLE;
          end
        end
        default: st_q <= XS_IDLE;
      endcase
    end
  end

  assign CS_n_o     = cs_n_q;
  assign Data_o     = data_q;
  assign Write_o    = wr_q;
  assign ReadNext_o = rn_q;
  assign Done_o     = done_q;
  assign Value_o    = val_q;

endmodule

// File: rtl/spi_sensor_poll_multi.sv
// Round-robin poller for NUM_CH ADT7310-class sensors on one SPI master.
// Define SPI_POLL_CHMASK_EN to add the ChEnable_i per-channel skip mask.
module spi_sensor_poll_multi
  import spi_sensor_poll_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int DATA_BYTES = 2,
  parameter int WAIT_W     = 32,
  parameter int PERIOD_W   = 16,
  localparam int VALUE_W   = 8 * DATA_BYTES
) (
  input  logic                      Clk_i,
  input  logic                      Reset_n_i,
  input  logic                      Enable_i,
`ifdef SPI_POLL_CHMASK_EN
  input  logic [NUM_CH-1:0]         ChEnable_i,
`endif
  output logic [NUM_CH-1:0]         CS_n_o,
  output logic [7:0]                SPI_Data_o,
  output logic                      SPI_Write_o,
  output logic                      SPI_ReadNext_o,
  input  logic [7:0]                SPI_Data_i,
  input  logic                      SPI_FIFOFull_i,
  input  logic                      SPI_FIFOEmpty_i,
  input  logic                      SPI_Transmission_i,
  input  logic [PERIOD_W-1:0]       PeriodPreset_i,
  input  logic [WAIT_W-1:0]         WaitPreset_i,
  input  logic [VALUE_W-1:0]        Threshold_i,
  output logic [NUM_CH*VALUE_W-1:0] SensorValue_o,
  output logic [NUM_CH-1:0]         IntrMask_o,
  output logic                      CpuIntr_o,
  output logic                      Busy_o
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  poll_state_e               state_q;
  logic [CH_W-1:0]           ch_q;
  logic [CH_W-1:0]           ch_nxt;
  logic [PERIOD_W-1:0]       period_q;
  logic [WAIT_W-1:0]         wait_q;
  logic                      busy_q;
  logic                      intr_q;
  logic [NUM_CH-1:0]         mask_q;
  logic [NUM_CH-1:0]         flags_q;
  logic [NUM_CH*VALUE_W-1:0] val_q;
  logic                      xstart_q;
  logic                      xread_q;
  logic                      x_done;
  logic [VALUE_W-1:0]        x_val;
  logic [VALUE_W-1:0]        cur_val;
  logic [VALUE_W-1:0]        diff;

  assign ch_nxt = ch_q + 1'b1;

  always_comb begin
    cur_val = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (CH_W'(k) == ch_q) cur_val = val_q[k*VALUE_W +: VALUE_W];
  end

  assign diff = (x_val >= cur_val) ? x_val - cur_val : cur_val - x_val;

`ifdef SPI_POLL_CHMASK_EN
  logic next_en;
  always_comb begin
    next_en = 1'b0;
    for (int k = 0; k < NUM_CH; k++)
      if (CH_W'(k) == ch_nxt) next_en = ChEnable_i[k];
  end
`endif

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state_q  <= ST_IDLE;
      ch_q     <= '0;
      period_q <= '0;
      wait_q   <= '0;
      busy_q   <= 1'b0;
      intr_q   <= 1'b0;
      mask_q   <= '0;
      flags_q  <= '0;
      val_q    <= '0;
      xstart_q <= 1'b0;
      xread_q  <= 1'b0;
    end else begin
      xstart_q <= 1'b0;
      intr_q   <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (Enable_i) begin
            period_q <= PeriodPreset_i;
            state_q  <= ST_PERIOD;
          end
        end
        ST_PERIOD: begin
          if (!Enable_i) begin
            state_q <= ST_IDLE;
          end else if (period_q == '0) begin
            ch_q    <= '0;
            busy_q  <= 1'b1;
            xread_q <= 1'b0;
`ifdef SPI_POLL_CHMASK_EN
            if (ChEnable_i[0]) begin
              xstart_q <= 1'b1;
              state_q  <= ST_CFG_XFER;
            end else begin
              state_q  <= ST_NEXT;
            end
`else
            xstart_q <= 1'b1;
            state_q  <= ST_CFG_XFER;
`endif
          end else begin
            period_q <= period_q - 1'b1;
          end
        end
        ST_CFG_XFER: begin
          if (x_done) begin
            if (!Enable_i) begin
              flags_q <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              wait_q  <= WaitPreset_i;
              state_q <= ST_CONV_WAIT;
            end
          end
        end
        ST_CONV_WAIT: begin
          if (!Enable_i) begin
            flags_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (wait_q == '0) begin
            xstart_q <= 1'b1;
            xread_q  <= 1'b1;
            state_q  <= ST_READ_XFER;
          end else begin
            wait_q <= wait_q - 1'b1;
          end
        end
        ST_READ_XFER: begin
          if (x_done) begin
            if (!Enable_i) begin
              flags_q <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_COMPARE;
            end
          end
        end
        ST_COMPARE: begin
          if (diff > Threshold_i) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (CH_W'(k) == ch_q) begin
                val_q[k*VALUE_W +: VALUE_W] <= x_val;
                flags_q[k] <= 1'b1;
              end
            end
          end
          state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (!Enable_i) begin
            flags_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end else if (ch_q == LAST_CH) begin
            state_q <= ST_REPORT;
          end else begin
            ch_q    <= ch_nxt;
            xread_q <= 1'b0;
`ifdef SPI_POLL_CHMASK_EN
            if (next_en) begin
              xstart_q <= 1'b1;
              state_q  <= ST_CFG_XFER;
            end
`else
            xstart_q <= 1'b1;
            state_q  <= ST_CFG_XFER;
`endif
          end
        end
        ST_REPORT: begin
          if (|flags_q) begin
            intr_q <= 1'b1;
            mask_q <= flags_q;
          end
          flags_q  <= '0;
          busy_q   <= 1'b0;
          period_q <= PeriodPreset_i;
          state_q  <= ST_PERIOD;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  spi_xfer_seq #(
    .NUM_CH     (NUM_CH),
    .DATA_BYTES (DATA_BYTES),
    .CH_W       (CH_W)
  ) u_xfer (
    .Clk_i          (Clk_i),
    .Reset_n_i      (Reset_n_i),
    .Start_i        (xstart_q),
    .Read_i         (xread_q),
    .Ch_i           (ch_q),
    .CS_n_o         (CS_n_o),
    .Data_o         (SPI_Data_o),
    .Write_o        (SPI_Write_o),
    .ReadNext_o     (SPI_ReadNext_o),
    .RxData_i       (SPI_Data_i),
    .FIFOFull_i     (SPI_FIFOFull_i),
    .FIFOEmpty_i    (SPI_FIFOEmpty_i),
    .Transmission_i (SPI_Transmission_i),
    .Done_o         (x_done),
    .Value_o        (x_val)
  );

  assign SensorValue_o = val_q;
  assign IntrMask_o    = mask_q;
  assign CpuIntr_o     = intr_q;
  assign Busy_o        = busy_q;

endmodule

// File: tb/tb_spi_sensor_poll_multi.sv
// Directed bench: two-channel 16-bit poller plus a one-channel
// 8-bit instance, each with a small SPI master/FIFO model.
module tb_spi_sensor_poll_multi;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // instance A: NUM_CH=2, DATA_BYTES=2
  logic        en_a, full_a;
  logic        empty_a = 1'b1, trans_a = 1'b0;
  logic [1:0]  cs_a, mask_a;
  logic [7:0]  dout_a, din_a;
  logic        wr_a, rn_a, intr_a, busy_a;
  logic [15:0] per_a, thr_a;
  logic [31:0] wait_a, val_a;

  // instance B: NUM_CH=1, DATA_BYTES=1
  logic        en_b;
  logic        empty_b = 1'b1, trans_b = 1'b0;
  logic [0:0]  cs_b, mask_b;
  logic [7:0]  dout_b, din_b, thr_b, val_b;
  logic        wr_b, rn_b, intr_b, busy_b;

  spi_sensor_poll_multi #(.NUM_CH(2), .DATA_BYTES(2)) u_dut (
    .Clk_i(clk), .Reset_n_i(rst_n), .Enable_i(en_a),
    .CS_n_o(cs_a), .SPI_Data_o(dout_a), .SPI_Write_o(wr_a),
    .SPI_ReadNext_o(rn_a), .SPI_Data_i(din_a),
    .SPI_FIFOFull_i(full_a), .SPI_FIFOEmpty_i(empty_a),
    .SPI_Transmission_i(trans_a), .PeriodPreset_i(per_a),
    .WaitPreset_i(wait_a), .Threshold_i(thr_a),
    .SensorValue_o(val_a), .IntrMask_o(mask_a),
    .CpuIntr_o(intr_a), .Busy_o(busy_a)
  );

  spi_sensor_poll_multi #(.NUM_CH(1), .DATA_BYTES(1)) u_dut_b (
    .Clk_i(clk), .Reset_n_i(rst_n), .Enable_i(en_b),
    .CS_n_o(cs_b), .SPI_Data_o(dout_b), .SPI_Write_o(wr_b),
    .SPI_ReadNext_o(rn_b), .SPI_Data_i(din_b),
    .SPI_FIFOFull_i(1'b0), .SPI_FIFOEmpty_i(empty_b),
    .SPI_Transmission_i(trans_b), .PeriodPreset_i(16'd0),
    .WaitPreset_i(32'd0), .Threshold_i(thr_b),
    .SensorValue_o(val_b), .IntrMask_o(mask_b),
    .CpuIntr_o(intr_b), .Busy_o(busy_b)
  );

  // SPI model A: TX log, 4-cycle byte shifter, RX stream
  logic [7:0] txa [0:255];
  logic [1:0] csa_log [0:255];
  int txa_n = 0, pend_a = 0, bit_a = 0;
  int cs_bad = 0, ch1_sel = 0, intr_cnt_a = 0;
  logic [7:0] rxa [0:63];
  int rxa_wr = 0, rxa_idx = 0;
  assign din_a = rxa[rxa_idx];

  always @(negedge clk) begin
    if (wr_a) begin
      txa[txa_n] = dout_a;
      csa_log[txa_n] = cs_a;
      txa_n++;
      pend_a++;
    end
    if (bit_a == 0 && pend_a > 0) begin
      bit_a = 4;
      pend_a--;
    end else if (bit_a > 0) begin
      bit_a--;
    end
    trans_a = (bit_a > 0);
    empty_a = (pend_a == 0);
    if (cs_a == 2'b00) cs_bad++;
    if (!cs_a[1]) ch1_sel++;
    if (intr_a) intr_cnt_a++;
  end

  always @(posedge clk) if (rn_a) rxa_idx <= rxa_idx + 1;

  // SPI model B
  logic [7:0] txb [0:63];
  int txb_n = 0, pend_b = 0, bit_b = 0;
  logic [7:0] rxb [0:15];
  int rxb_idx = 0;
  assign din_b = rxb[rxb_idx];

  always @(negedge clk) begin
    if (wr_b) begin
      txb[txb_n] = dout_b;
      txb_n++;
      pend_b++;
    end
    if (bit_b == 0 && pend_b > 0) begin
      bit_b = 4;
      pend_b--;
    end else if (bit_b > 0) begin
      bit_b--;
    end
    trans_b = (bit_b > 0);
    empty_b = (pend_b == 0);
  end

  always @(posedge clk) if (rn_b) rxb_idx <= rxb_idx + 1;

  logic [7:0] seq_a [5] = '{8'h08, 8'h20, 8'h50, 8'hFF, 8'hFF};

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_a(input logic [7:0] b);
    rxa[rxa_wr] = b;
    rxa_wr++;
  endtask

  task automatic check_sweep_tx(input int base);
    for (int c = 0; c < 2; c++) begin
      for (int i = 0; i < 5; i++) begin
        int j;
        logic [1:0] cs_exp;
        j = base + 5 * c + i;
        cs_exp = (c == 0) ? 2'b10 : 2'b01;
        chk($sformatf("sweep_tx[%0d]", j),
            {csa_log[j], txa[j]}, {cs_exp, seq_a[i]});
      end
    end
  endtask

  initial begin
    int base, n0, lowcnt, ch1s, icnt;
    rst_n  = 1'b0;
    en_a   = 1'b0;
    en_b   = 1'b0;
    full_a = 1'b0;
    per_a  = 16'd3;
    wait_a = 32'd5;
    thr_a  = 16'h0010;
    thr_b  = 8'h00;
    repeat (3) @(negedge clk);

    chk("rst_cs", cs_a, 2'b11);
    chk("rst_wr_rn_intr_busy", {wr_a, rn_a, intr_a, busy_a}, 4'b0);
    chk("rst_data_val_mask", {dout_a, val_a, mask_a}, 42'd0);
    chk("rst_cs_b", cs_b, 1'b1);
    rst_n = 1'b1;

    // reset while the read command is on the wire
    en_a = 1'b1;
    for (int i = 0; i < 400 && txa_n < 3; i++) @(negedge clk);
    chk("midread_reached", txa_n, 3);
    chk("midread_byte", txa[2], 8'h50);
    rst_n = 1'b0;
    #1;
    chk("midrst_cs", cs_a, 2'b11);
    chk("midrst_outs", {wr_a, rn_a, intr_a, busy_a}, 4'b0);
    chk("midrst_data_val", {dout_a, val_a, mask_a}, 42'd0);
    en_a = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = txa_n;
    repeat (30) @(negedge clk);
    chk("idle_after_rst", {txa_n, busy_a, cs_a}, {n0, 1'b0, 2'b11});

    // sweep 1: first readings against 0
    base = txa_n;
    push_a(8'h00); push_a(8'h0C); push_a(8'h80);
    push_a(8'h00); push_a(8'h0C); push_a(8'h00);
    en_a = 1'b1;
    for (int i = 0; i < 1000 && !intr_a; i++) @(negedge clk);
    chk("sw1_intr", intr_a, 1'b1);
    chk("sw1_mask", mask_a, 2'b11);
    chk("sw1_vals", val_a, 32'h0C00_0C80);
    check_sweep_tx(base);

    // sweep 2: ch0 diff 8, ch1 diff 0x11
    base = txa_n;
    push_a(8'h00); push_a(8'h0C); push_a(8'h88);
    push_a(8'h00); push_a(8'h0C); push_a(8'h11);
    @(negedge clk);
    chk("sw1_pulse_width", intr_a, 1'b0);
    chk("sw1_intr_cnt", intr_cnt_a, 1);
    for (int i = 0; i < 1000 && !intr_a; i++) @(negedge clk);
    chk("sw2_intr", intr_a, 1'b1);
    chk("sw2_mask", mask_a, 2'b10);
    chk("sw2_vals", val_a, 32'h0C11_0C80);
    check_sweep_tx(base);
    @(negedge clk);
    chk("sw2_intr_cnt", intr_cnt_a, 2);

    // sweep 3: both diffs exactly the threshold
    push_a(8'h00); push_a(8'h0C); push_a(8'h70);
    push_a(8'h00); push_a(8'h0C); push_a(8'h21);
    for (int i = 0; i < 200 && !busy_a; i++) @(negedge clk);
    for (int i = 0; i < 1000 && busy_a; i++) @(negedge clk);
    @(negedge clk);
    chk("sw3_done", busy_a, 1'b0);
    chk("sw3_no_intr", intr_cnt_a, 2);
    chk("sw3_mask_hold", mask_a, 2'b10);
    chk("sw3_vals", val_a, 32'h0C11_0C80);

    // sweep 4: TX FIFO full stalls the config writes
    base = txa_n;
    push_a(8'h00); push_a(8'h0C); push_a(8'h80);
    push_a(8'h00); push_a(8'h0C); push_a(8'h11);
    for (int i = 0; i < 200 && cs_a == 2'b11; i++) @(negedge clk);
    full_a = 1'b1;
    @(negedge clk);
    n0 = txa_n;
    lowcnt = 0;
    repeat (5) begin
      @(negedge clk);
      if (cs_a == 2'b10) lowcnt++;
    end
    chk("stall_no_early_wr", n0, base);
    chk("stall_no_wr", txa_n, n0);
    chk("stall_cs_low", lowcnt, 5);
    full_a = 1'b0;
    for (int i = 0; i < 1000 && busy_a; i++) @(negedge clk);
    @(negedge clk);
    chk("sw4_done", busy_a, 1'b0);
    check_sweep_tx(base);
    chk("sw4_no_intr", intr_cnt_a, 2);

    // sweep 5: Enable_i dropped during ch0 conversion wait
    wait_a = 32'd60;
    base = txa_n;
    ch1s = ch1_sel;
    icnt = intr_cnt_a;
    for (int i = 0; i < 400 && !(txa_n == base + 2 && cs_a == 2'b11); i++)
      @(negedge clk);
    chk("abort_cfg_done", txa_n, base + 2);
    en_a = 1'b0;
    repeat (150) @(negedge clk);
    chk("abort_no_wr", txa_n, base + 2);
    chk("abort_no_intr", intr_cnt_a, icnt);
    chk("abort_idle", {busy_a, cs_a}, {1'b0, 2'b11});
    chk("abort_ch1_unsel", ch1_sel, ch1s);
    chk("abort_vals", val_a, 32'h0C11_0C80);
    chk("one_cs_low", cs_bad, 0);

    // one byte per sample, zero period and wait presets
    rxb[0] = 8'hAA;
    rxb[1] = 8'h5C;
    en_b = 1'b1;
    for (int i = 0; i < 400 && !intr_b; i++) @(negedge clk);
    en_b = 1'b0;
    chk("b_intr", intr_b, 1'b1);
    chk("b_val", val_b, 8'h5C);
    chk("b_mask", mask_b, 1'b1);
    chk("b_tx_n", txb_n, 4);
    chk("b_tx", {txb[0], txb[1], txb[2], txb[3]}, 32'h0820_50FF);
    chk("b_pops", rxb_idx, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
